// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - opcodes, FSM encodings and decode helpers for the hazard controller
package pipeline_hazard_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_SB    = 6'd40;
   localparam logic [5:0] OP_SH    = 6'd41;
   localparam logic [5:0] OP_SWL   = 6'd42;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_SWR   = 6'd46;
   localparam logic [5:0] OP_HALT  = 6'd63;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DRAIN  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic pipe_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(6'b000_000);
   localparam pipe_ctrl_t CTRL_ADVANCE  = pipe_ctrl_t'(6'b111_000);
   localparam pipe_ctrl_t CTRL_BUBBLE   = pipe_ctrl_t'(6'b001_010);
   localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(6'b111_111);
   localparam pipe_ctrl_t CTRL_RESUME   = pipe_ctrl_t'(6'b100_100);

   // j, jal and lui carry no register source in the rs field
   function automatic logic uses_rs(input logic [5:0] op);
      return !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
   endfunction

   // rt is a source only for R-type, branches compare and stores (store data)
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) ||
             (op == OP_SB) || (op == OP_SH) || (op == OP_SWL) ||
             (op == OP_SW) || (op == OP_SWR);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// rtl/pipeline_hazard_ctrl_load_use_detect.sv - combinational load-use hazard detect for the ID stage
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [31:0] id_instr,
   input  logic        ex_memread,
   input  logic [4:0]  ex_rt,
   output logic        load_use
);

   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       rs_hit;
   logic       rt_hit;
   logic       unused_imm;

   assign op = id_instr[31:26];
   assign rs = id_instr[25:21];
   assign rt = id_instr[20:16];
   assign unused_imm = ^id_instr[15:0];

   assign rs_hit = uses_rs(op) && (ex_rt == rs);
   assign rt_hit = uses_rt(op) && (ex_rt == rt);

   // $zero is never a real dependency even when a load targets it
   assign load_use = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline sequencing: load-use stall, redirect flush, memory freeze, halt drain
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int          DRAIN_CYCLES = 3,
   parameter int          CNT_W        = 32,
   parameter logic [5:0]  HALT_OP      = OP_HALT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      id_instr,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             mem_redirect,
   input  logic             mem_stall_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             pipe_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   logic [1:0]         state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   pipe_ctrl_t         ctrl;
   logic               load_use;
   logic               halt_op;

   load_use_detect u_load_use_detect (
      .id_instr   (id_instr),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .load_use   (load_use)
   );

   assign halt_op = (id_instr[31:26] == HALT_OP);

   always_comb begin
      ctrl    = CTRL_FREEZE;
      state_d = state_q;
      drain_d = drain_q;
      cnt_d   = cnt_q;
      // a memory stall freezes everything, including the HALTED resume path
      if (!mem_stall_req) begin
         case (state_q)
            ST_RUN: begin
               if (mem_redirect) begin
                  ctrl = CTRL_REDIRECT;
               end else if (halt_op) begin
                  ctrl    = CTRL_BUBBLE;
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
               end else if (load_use) begin
                  ctrl  = CTRL_BUBBLE;
                  cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
               end else begin
                  ctrl = CTRL_ADVANCE;
               end
            end
            ST_DRAIN: begin
               if (mem_redirect) begin
                  ctrl    = CTRL_REDIRECT;
                  state_d = ST_RUN;
                  drain_d = '0;
               end else begin
                  ctrl = CTRL_BUBBLE;
                  if (drain_q == '0) begin
                     state_d = ST_HALTED;
                  end else begin
                     drain_d = drain_q - 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               // IF/ID still holds the halt; kill it so it is not decoded again
               if (resume) begin
                  ctrl    = CTRL_RESUME;
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
               drain_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_en        = rst_n & ctrl.pc_en;
   assign if_id_en     = rst_n & ctrl.if_id_en;
   assign pipe_en      = rst_n & ctrl.pipe_en;
   assign if_id_flush  = rst_n & ctrl.if_id_flush;
   assign id_ex_flush  = rst_n & ctrl.id_ex_flush;
   assign ex_mem_flush = rst_n & ctrl.ex_mem_flush;
   assign halted       = rst_n & (state_q == ST_HALTED);
   assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with a behavioural model and literal pins for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   localparam int TB_CNT_W = 3;
   localparam int TB_DRAIN = 3;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

   // {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush, halted}
   localparam logic [6:0] O_ZERO   = 7'b000_000_0;
   localparam logic [6:0] O_RUN    = 7'b111_000_0;
   localparam logic [6:0] O_STALL  = 7'b001_010_0;
   localparam logic [6:0] O_FLUSH  = 7'b111_111_0;
   localparam logic [6:0] O_HALT   = 7'b000_000_1;
   localparam logic [6:0] O_RESUME = 7'b100_100_1;

   localparam logic [31:0] I_NOP  = 32'h0000_0000;
   localparam logic [31:0] I_ADD  = 32'h0023_1020;
   localparam logic [31:0] I_SW   = 32'hAC85_0000;
   localparam logic [31:0] I_ADDI = 32'h2086_0001;
   localparam logic [31:0] I_LUI  = 32'h3C27_0001;
   localparam logic [31:0] I_HALT = 32'hFC00_0000;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [31:0]         id_instr = '0;
   logic                ex_memread = 1'b0;
   logic [4:0]          ex_rt = '0;
   logic                mem_redirect = 1'b0;
   logic                mem_stall_req = 1'b0;
   logic                resume = 1'b0;
   logic                pc_en, if_id_en, pipe_en;
   logic                if_id_flush, id_ex_flush, ex_mem_flush, halted;
   logic [TB_CNT_W-1:0] stall_cnt;

   bit                  pin_valid = 1'b0;
   logic [6:0]          pin_o = '0;
   logic [TB_CNT_W-1:0] pin_c = '0;
   int                  vec_no = 0;

   bit                  m_draining = 1'b0;
   bit                  m_parked = 1'b0;
   int                  m_left = 0;
   int                  m_cnt = 0;

   int                  vectors = 0;
   int                  miscompares = 0;

   pipeline_hazard_ctrl #(
      .DRAIN_CYCLES (TB_DRAIN),
      .CNT_W        (TB_CNT_W),
      .HALT_OP      (6'd63)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_instr      (id_instr),
      .ex_memread    (ex_memread),
      .ex_rt         (ex_rt),
      .mem_redirect  (mem_redirect),
      .mem_stall_req (mem_stall_req),
      .resume        (resume),
      .pc_en         (pc_en),
      .if_id_en      (if_id_en),
      .pipe_en       (pipe_en),
      .if_id_flush   (if_id_flush),
      .id_ex_flush   (id_ex_flush),
      .ex_mem_flush  (ex_mem_flush),
      .halted        (halted),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit hazard(input logic [31:0] ins, input logic mr, input logic [4:0] rt);
      int  op;
      bit  rs_src, rt_src;
      op     = int'(ins[31:26]);
      rs_src = !(op inside {2, 3, 15});
      rt_src = op inside {0, 4, 5, 40, 41, 42, 43, 46};
      return mr && rt != 0 &&
             ((rs_src && rt == ins[25:21]) || (rt_src && rt == ins[20:16]));
   endfunction

   function automatic logic [6:0] model_out(input bit drn, input bit prk,
                                            input logic [31:0] ins, input logic mr,
                                            input logic [4:0] rt, input logic rd,
                                            input logic st, input logic rsm);
      if (st) return prk ? O_HALT : O_ZERO;
      if (prk) return rsm ? O_RESUME : O_HALT;
      if (rd) return O_FLUSH;
      if (drn || ins[31:26] == 6'd63 || hazard(ins, mr, rt)) return O_STALL;
      return O_RUN;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_draining <= 1'b0;
         m_parked   <= 1'b0;
         m_left     <= 0;
         m_cnt      <= 0;
      end else if (mem_stall_req) begin
      end else if (m_parked) begin
         if (resume) m_parked <= 1'b0;
      end else if (mem_redirect) begin
         m_draining <= 1'b0;
      end else if (m_draining) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_draining <= 1'b0;
            m_parked   <= 1'b1;
         end
      end else if (id_instr[31:26] == 6'd63) begin
         m_draining <= 1'b1;
         m_left     <= TB_DRAIN;
      end else if (hazard(id_instr, ex_memread, ex_rt)) begin
         m_cnt <= (m_cnt == CNT_MAX) ? m_cnt : m_cnt + 1;
      end
   end

   always @(negedge clk) begin : compare
      logic [6:0]          exp_o;
      logic [TB_CNT_W-1:0] exp_c;
      logic [6:0]          act_o;
      if (!rst_n) begin
         exp_o = O_ZERO;
         exp_c = '0;
      end else begin
         exp_o = model_out(m_draining, m_parked, id_instr, ex_memread, ex_rt,
                           mem_redirect, mem_stall_req, resume);
         exp_c = TB_CNT_W'(m_cnt);
      end
      act_o = {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush, halted};
      vectors++;
      if (act_o !== exp_o || stall_cnt !== exp_c) begin
         miscompares++;
         $display("FAIL model vec %0d: outputs %b cnt %0d, required %b cnt %0d",
                  vec_no, act_o, stall_cnt, exp_o, exp_c);
      end
      if (pin_valid) begin
         vectors++;
         if (act_o !== pin_o || stall_cnt !== pin_c || exp_o !== pin_o || exp_c !== pin_c) begin
            miscompares++;
            $display("FAIL pin vec %0d: dut %b cnt %0d, model %b cnt %0d, required %b cnt %0d",
                     vec_no, act_o, stall_cnt, exp_o, exp_c, pin_o, pin_c);
         end
      end
   end

   task automatic step(input logic rn, input logic [31:0] ins, input logic mr,
                       input logic [4:0] rt, input logic rd, input logic st,
                       input logic rsm, input bit pv, input logic [6:0] po, input int pc);
      @(posedge clk);
      #1;
      rst_n         = rn;
      id_instr      = ins;
      ex_memread    = mr;
      ex_rt         = rt;
      mem_redirect  = rd;
      mem_stall_req = st;
      resume        = rsm;
      pin_valid     = pv;
      pin_o         = po;
      pin_c         = TB_CNT_W'(pc);
      vec_no++;
   endtask

   initial begin
      // reset, then load-use on rs, $zero destination
      step(0, I_NOP,  0, 0, 0, 0, 0, 1, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   0);
      step(1, I_ADD,  1, 1, 0, 0, 0, 1, O_STALL, 0);
      step(1, I_ADD,  0, 0, 0, 0, 0, 1, O_RUN,   1);
      step(1, I_ADD,  1, 0, 0, 0, 0, 1, O_RUN,   1);
      // store data is a source, immediate rt is not, lui ignores rs
      step(1, I_SW,   1, 5, 0, 0, 0, 1, O_STALL, 1);
      step(1, I_SW,   0, 0, 0, 0, 0, 1, O_RUN,   2);
      step(1, I_ADDI, 1, 6, 0, 0, 0, 1, O_RUN,   2);
      step(1, I_ADDI, 1, 4, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_LUI,  1, 1, 0, 0, 0, 1, O_RUN,   3);
      // back-to-back loads, then redirect beats load-use and halt
      step(1, I_ADD,  1, 1, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_ADD,  1, 3, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   5);
      step(1, I_ADD,  1, 1, 1, 0, 0, 1, O_FLUSH, 5);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   5);
      step(1, I_HALT, 0, 0, 1, 0, 0, 1, O_FLUSH, 5);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   5);
      // counter saturation at 2**CNT_W-1
      step(1, I_ADD,  1, 1, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_ADD,  1, 1, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_ADD,  1, 1, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   7);
      // halt drain, park, ignored redirect, resume
      step(1, I_HALT, 0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_ADD,  1, 1, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_HALT,  7);
      step(1, I_NOP,  0, 0, 1, 0, 0, 1, O_HALT,  7);
      step(1, I_HALT, 0, 0, 0, 0, 1, 1, O_RESUME, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   7);
      // halt on wrong path
      step(1, I_HALT, 0, 0, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 1, 0, 0, 1, O_FLUSH, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   7);
      for (int i = 0; i < 4; i++) step(1, I_NOP, 0, 0, 0, 0, 0, 1, O_RUN, 7);
      // freeze mid-drain holds the drain count; freeze in HALTED blocks resume
      step(1, I_HALT, 0, 0, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 0, O_ZERO,  0);
      for (int i = 0; i < 4; i++) step(1, I_NOP, 0, 0, 1, 1, 0, 1, O_ZERO, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_HALT,  7);
      step(1, I_NOP,  0, 0, 0, 1, 1, 1, O_HALT,  7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_HALT,  7);
      step(1, I_HALT, 0, 0, 0, 0, 1, 1, O_RESUME, 7);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   7);
      // reset mid-drain
      step(1, I_HALT, 0, 0, 0, 0, 0, 0, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_STALL, 7);
      step(0, I_NOP,  0, 0, 0, 0, 0, 1, O_ZERO,  0);
      step(0, I_HALT, 1, 1, 1, 0, 1, 1, O_ZERO,  0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   0);
      // freeze outranks load-use and redirect in RUN
      step(1, I_ADD,  1, 1, 0, 1, 0, 1, O_ZERO,  0);
      step(1, I_ADD,  1, 1, 0, 0, 0, 1, O_STALL, 0);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   1);
      step(1, I_NOP,  0, 0, 1, 1, 0, 1, O_ZERO,  1);
      step(1, I_NOP,  0, 0, 0, 0, 0, 1, O_RUN,   1);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
